// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, FSM encoding and control-bundle helpers for the pipeline
// stall/flush sequencer.
package cpu_ctrl_pkg;

  localparam int REG_ADDR_W         = 3;
  localparam int WORD_W             = 19;
  localparam int MDU_MAX_CYCLES_DEF = 16;

  typedef logic [0:0] ctrl_state_t;

  localparam ctrl_state_t RUN      = 1'b0;
  localparam ctrl_state_t MDU_BUSY = 1'b1;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic mdu_wb;
  } ctrl_out_t;

  // Canned enable/flush combinations, one per pipeline situation.
  localparam ctrl_out_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                        id_ex_flush: 1'b1, pipe_freeze: 1'b0, mdu_wb: 1'b0};
  localparam ctrl_out_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                        id_ex_flush: 1'b0, pipe_freeze: 1'b1, mdu_wb: 1'b0};
  localparam ctrl_out_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                        id_ex_flush: 1'b1, pipe_freeze: 1'b0, mdu_wb: 1'b0};
  localparam ctrl_out_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                        id_ex_flush: 1'b1, pipe_freeze: 1'b0, mdu_wb: 1'b0};
  localparam ctrl_out_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                        id_ex_flush: 1'b0, pipe_freeze: 1'b0, mdu_wb: 1'b0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
    if (en && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Busy-cycle counter for the multiply/divide unit: clear on issue, hold while
// frozen or idle, and flag the cycle that would be the last allowed one.
module mdu_timer #(
  parameter int MAX_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CYCLES);

  logic [CNT_W-1:0] count;

  // Saturates at MAX_CYCLES so a stray enable after timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold && (count != MAX_VAL)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = !hold && (count == TC_VAL);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch,
// memory wait and MDU handshake. Define PIPE_CTRL_PERF_EN for perf counters.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = MDU_MAX_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hazard,
  input  logic branch_taken,
  input  logic mem_busy,
  input  logic ID_mdu,
  input  logic mdu_done,
  output logic PCwrite,
  output logic IF_IDwrite,
  output logic IF_IDflush,
  output logic ID_EXflush,
  output logic pipe_freeze,
  output logic mdu_start,
  output logic mdu_wb,
  output logic mdu_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_flush,
  output logic [15:0] perf_freeze
`endif
);

  localparam int CNT_W = $clog2(MDU_MAX_CYCLES + 1);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  ctrl_out_t   ctrl;
  logic        done_pend;
  logic        mdu_err_q;
  logic        mdu_start_q;
  logic        issue;
  logic        complete;
  logic        timeout;
  logic        cnt_tc;
  logic        cnt_hold;

  // A wrong-path or hazard-stalled MDU op must not start the unit.
  assign issue    = (state == RUN) && !mem_busy && !branch_taken && !hazard && ID_mdu;
  assign complete = (state == MDU_BUSY) && !mem_busy && (mdu_done || done_pend);
  assign timeout  = (state == MDU_BUSY) && cnt_tc && !complete;
  assign cnt_hold = mem_busy || (state != MDU_BUSY);

  mdu_timer #(
    .MAX_CYCLES (MDU_MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (issue),
    .hold  (cnt_hold),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_nxt = state;
    if (issue) begin
      state_nxt = MDU_BUSY;
    end else if (complete || timeout) begin
      state_nxt = RUN;
    end
  end

  // Reset forces the flush-everything bundle even before the first clock edge.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (state == MDU_BUSY) begin
      ctrl        = CTRL_BUBBLE;
      ctrl.mdu_wb = complete;
    end else if (branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (hazard || ID_mdu) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      done_pend   <= 1'b0;
      mdu_err_q   <= 1'b0;
      mdu_start_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      mdu_start_q <= issue;
      mdu_err_q   <= mdu_err_q || timeout;
      if (complete) begin
        done_pend <= 1'b0;
      end else if ((state == MDU_BUSY) && mem_busy && mdu_done) begin
        done_pend <= 1'b1;
      end
    end
  end

  assign PCwrite     = ctrl.pc_write;
  assign IF_IDwrite  = ctrl.if_id_write;
  assign IF_IDflush  = ctrl.if_id_flush;
  assign ID_EXflush  = ctrl.id_ex_flush;
  assign pipe_freeze = ctrl.pipe_freeze;
  assign mdu_wb      = ctrl.mdu_wb;
  assign mdu_start   = mdu_start_q;
  assign mdu_err     = mdu_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] freeze_cnt;
  logic        branch_flush;

  assign branch_flush = (state == RUN) && !mem_busy && branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= 16'd0;
      flush_cnt  <= 16'd0;
      freeze_cnt <= 16'd0;
    end else begin
      stall_cnt  <= sat_inc16(stall_cnt, !ctrl.pc_write && !mem_busy);
      flush_cnt  <= sat_inc16(flush_cnt, branch_flush);
      freeze_cnt <= sat_inc16(freeze_cnt, mem_busy);
    end
  end

  assign perf_stall  = stall_cnt;
  assign perf_flush  = flush_cnt;
  assign perf_freeze = freeze_cnt;
`endif

endmodule
